uart_kbd_led_ctrl: RTL
======================

# uart_kbd_led_ctrl

Host-to-keyboard command path for the GateMate USB HID host design. It receives ASCII commands on the FTDI UART line (`ftdi_txd`, FPGA input) in the 12 MHz USB clock domain. It parses `L<hex>` followed by CR or LF, then drives the keyboard LED nibble and a one-cycle update strobe into `usb_hid_host` (`leds`, `update_leds_stb`). It is the reverse direction of the report/print path: data flows from the PC towards the USB keyboard.

## Interface
- `CLK_HZ`, default 12000000: `usbclk` frequency in Hz.
- `BAUD`, default 115200: UART bit rate. Bit period `DIV = (CLK_HZ + BAUD/2) / BAUD`, which is 104 at the defaults. Half period `HALF = DIV/2`, which is 52.
- `usbclk  in  1`: single clock. All logic is on its rising edge.
- `usbrst_n  in  1`: asynchronous, active-low reset.
- `uart_rx  in  1`: UART receive line, 8N1, idle high, asynchronous to `usbclk`.
- `leds  out  4`: keyboard LED state, bit0 NumLock, bit1 CapsLock, bit2 ScrollLock, bit3 Compose. Reset value 4'b0000.
- `update_leds_stb  out  1`: one-cycle pulse when `leds` takes a new value. Reset value 0.
- `frame_err  out  1`: one-cycle pulse when a byte's stop bit is sampled low. Reset value 0.
- `cmd_err  out  1`: one-cycle pulse when a byte violates the command grammar. Reset value 0.

## Operation
- Input sync: a 2-flop synchronizer on `uart_rx`, both flops resetting to 1. All RX logic uses the synchronized value `rxs`.
- RX FSM states are `R_IDLE`, `R_START`, `R_DATA`, `R_STOP`, `R_BREAK`. The baud counter is `$clog2(DIV)` bits wide and the bit index is 3 bits.
  - `R_IDLE`: when `rxs` is 0, load the counter with `HALF-1` and go to `R_START`.
  - `R_START`: when the counter reaches 0, sample `rxs`. If it is 1, this was a glitch: return to `R_IDLE` with no error. If it is 0, reload `DIV-1` and go to `R_DATA`.
  - `R_DATA`: sample 8 bits, LSB first, one every `DIV` cycles. Shift them into the byte register. After bit 7, go to `R_STOP`.
  - `R_STOP`: sample after `DIV` cycles.
    - If 1: raise the internal `byte_vld` for one cycle and go to `R_IDLE`.
    - If 0: pulse `frame_err`, discard the byte, reset the parser to `P_IDLE` and go to `R_BREAK`.
  - `R_BREAK`: wait until `rxs` is 1, then go to `R_IDLE`. No start bit is detected during a break.
- Parser FSM states are `P_IDLE`, `P_GOT_L`, `P_GOT_HEX`. It advances only on `byte_vld`. It holds a 4-bit `nib` register, reset value 0.
  - `P_IDLE`:
    - 'L' (0x4C) or 'l' (0x6C): go to `P_GOT_L`.
    - CR (0x0D) or LF (0x0A): ignored silently, so CRLF and blank lines are legal.
    - Any other byte: pulse `cmd_err` and stay in `P_IDLE`.
  - `P_GOT_L`:
    - Hex digit '0'-'9', 'A'-'F' or 'a'-'f': `nib` takes its value and the FSM goes to `P_GOT_HEX`.
    - Any other byte, including 'L', CR and LF: pulse `cmd_err` and go to `P_IDLE`.
  - `P_GOT_HEX`:
    - CR or LF: `leds` takes `nib`, pulse `update_leds_stb`, go to `P_IDLE`.
    - Any other byte: pulse `cmd_err` and go to `P_IDLE`. `leds` is unchanged.
- The strobe fires on every valid command, even when the value equals the current `leds`.
- `leds` changes only on a valid terminator or on reset.
- `frame_err`, `cmd_err` and `update_leds_stb` are mutually exclusive in any cycle.

## Timing
- The synchronizer adds 2 cycles of latency.
- Samples are taken at bit centres: the start bit at `HALF` cycles after the detected edge, each later bit `DIV` cycles apart.
- `byte_vld` is asserted in the cycle after the stop-bit sample.
- `leds`, `update_leds_stb` and `cmd_err` are registered, one edge after `byte_vld`.
- End-to-end latency at the defaults: from the synchronized falling start edge of the terminator byte to `update_leds_stb` high is `HALF + 9*DIV + 2` = 990 cycles, ±1.
- Back-to-back bytes with a single stop bit are received without loss. The FSM is back in `R_IDLE` about half a bit before the next start edge.
- The design tolerates ±2% baud mismatch.
- Asynchronous reset mid-frame or mid-command: both FSMs return to their idle states and all outputs take their reset values immediately. The partial byte and partial command are discarded. After reset, no byte is accepted until a fresh falling edge is seen with `rxs` previously high.

## Test plan
- Send "L5\r" at 115200 baud with ideal timing. `leds` goes from 0000 to 0101, `update_leds_stb` is high for exactly 1 cycle, about 990 cycles after the '\r' start edge. Neither error output pulses.
- Send "lA\n" back-to-back with no idle gap, then "LF\r\n". `leds` becomes 1010, then 1111. Exactly two strobes occur. The trailing '\n' produces no `cmd_err`.
- Send "LG\r". `cmd_err` pulses once on 'G'. The '\r' is then silently ignored in `P_IDLE`. `leds` is unchanged and no strobe occurs.
- Send 'L' followed by a byte whose stop bit is held low, then hold the line low for 2000 cycles, then send "L3\r". `frame_err` pulses once and no bytes are decoded during the low period. `leds` ends at 0011.
- Apply a 30-cycle low glitch on `uart_rx` while idle. No byte is decoded and no output pulses.
- Send "L7\r" at BAUD×1.02 and at BAUD×0.98. `leds` is 0111 in both runs.
- Assert `usbrst_n` low during bit 4 of the '\r' of "L9\r", with `leds` previously 0101. `leds` becomes 0000 asynchronously. After release, "L1\r" gives `leds` 0001 with one strobe.

Source files
------------

// File: rtl/uart_kbd_led_ctrl.sv
// UART command receiver: decodes "L<hex>" + CR/LF into the keyboard LED nibble
// and a one-cycle update strobe for the USB HID host, all in the usbclk domain.
module uart_kbd_led_ctrl #(
    parameter int CLK_HZ = 12000000,
    parameter int BAUD   = 115200
) (
    input  logic       usbclk,
    input  logic       usbrst_n,
    input  logic       uart_rx,
    output logic [3:0] leds,
    output logic       update_leds_stb,
    output logic       frame_err,
    output logic       cmd_err
);

    localparam int DIV  = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV);
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
    localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);

    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_BREAK} rx_state_t;
    typedef enum logic [1:0] {P_IDLE, P_GOT_L, P_GOT_HEX} p_state_t;

    logic          rx_meta, rxs;
    rx_state_t     rx_state, rx_next;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    rx_byte;
    logic          byte_vld;
    logic          tick, load_half, load_div, data_smp, stop_ok, stop_bad;

    p_state_t      p_state, p_next;
    logic [3:0]    nib;
    logic [4:0]    hex;
    logic          is_l, is_eol, nib_ld, upd_d, err_d;

    // The line idles high, so the synchronizer resets to 1 to avoid a false start bit.
    always_ff @(posedge usbclk or negedge usbrst_n) begin
        if (!usbrst_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            // NOTE: sequential state always uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            rx_meta <= uart_rx;
            rxs     <= rx_meta;
        end
    end

    assign tick = (cnt == '0);

    always_ff @(posedge usbclk or negedge usbrst_n) begin
        if (!usbrst_n) rx_state <= R_IDLE;
        else           rx_state <= rx_next;
    end

    always_comb begin
        // NOTE: default first, so no path through the case leaves rx_next unassigned
        // and no latch is inferred.
        rx_next = rx_state;
        case (rx_state)
            R_IDLE:  if (!rxs) rx_next = R_START;
            R_START: if (tick) rx_next = rxs ? R_IDLE : R_DATA;
            R_DATA:  if (tick && bit_idx == 3'd7) rx_next = R_STOP;
            R_STOP:  if (tick) rx_next = rxs ? R_IDLE : R_BREAK;
            R_BREAK: if (rxs) rx_next = R_IDLE;
            default: rx_next = R_IDLE;
        endcase
    end

    always_comb begin
        load_half = (rx_state == R_IDLE) && !rxs;
        data_smp  = (rx_state == R_DATA) && tick;
        load_div  = ((rx_state == R_START) && tick && !rxs) || data_smp;
        stop_ok   = (rx_state == R_STOP) && tick && rxs;
        stop_bad  = (rx_state == R_STOP) && tick && !rxs;
    end

    // Baud counter reloads on each sample; it parks at zero while idle or in a break.
    always_ff @(posedge usbclk or negedge usbrst_n) begin
        if (!usbrst_n) begin
            cnt       <= '0;
            bit_idx   <= 3'd0;
            rx_byte   <= 8'h00;
            byte_vld  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (load_half)     cnt <= HALF_M1;
            else if (load_div) cnt <= DIV_M1;
            else if (!tick)    cnt <= cnt - 1'b1;

            if (rx_state == R_START) bit_idx <= 3'd0;
            else if (data_smp)       bit_idx <= bit_idx + 3'd1;

            if (data_smp) rx_byte <= {rxs, rx_byte[7:1]};

            byte_vld  <= stop_ok;
            frame_err <= stop_bad;
        end
    end

    function automatic logic [4:0] hex_decode(input logic [7:0] c);
        hex_decode = 5'b0_0000;
        if (c >= 8'h30 && c <= 8'h39)
            hex_decode = {1'b1, c[3:0]};
        else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66))
            hex_decode = {1'b1, c[3:0] + 4'd9};
    endfunction

    assign hex    = hex_decode(rx_byte);
    assign is_l   = (rx_byte == 8'h4C) || (rx_byte == 8'h6C);
    assign is_eol = (rx_byte == 8'h0D) || (rx_byte == 8'h0A);

    always_ff @(posedge usbclk or negedge usbrst_n) begin
        if (!usbrst_n) p_state <= P_IDLE;
        else           p_state <= p_next;
    end

    // A framing error abandons any half-parsed command.
    always_comb begin
        p_next = p_state;
        if (frame_err) begin
            p_next = P_IDLE;
        end else if (byte_vld) begin
            case (p_state)
                P_IDLE:    if (is_l) p_next = P_GOT_L;
                P_GOT_L:   p_next = hex[4] ? P_GOT_HEX : P_IDLE;
                P_GOT_HEX: p_next = P_IDLE;
                default:   p_next = P_IDLE;
            endcase
        end
    end

    always_comb begin
        nib_ld = 1'b0;
        upd_d  = 1'b0;
        err_d  = 1'b0;
        if (byte_vld && !frame_err) begin
            case (p_state)
                P_IDLE:    err_d = !is_l && !is_eol;
                P_GOT_L:   begin nib_ld = hex[4]; err_d = !hex[4]; end
                P_GOT_HEX: begin upd_d = is_eol; err_d = !is_eol; end
                default:   err_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge usbclk or negedge usbrst_n) begin
        if (!usbrst_n) begin
            nib             <= 4'h0;
            leds            <= 4'h0;
            update_leds_stb <= 1'b0;
            cmd_err         <= 1'b0;
        end else begin
            if (nib_ld) nib  <= hex[3:0];
            if (upd_d)  leds <= nib;
            update_leds_stb <= upd_d;
            cmd_err         <= err_d;
        end
    end

endmodule
